// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
// Holds the FSM state encoding, RV32I func3 width codes, controller opcodes
// and the func3 legality helper used by lsu_mem_iface.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Stores only have signed-width codes; loads add the unsigned variants.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        return we ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
                  : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane steering for the load/store unit.
// Ports: func3/addr_lo/we describe the access; wdata -> wstrb/wdata_rep are
// store strobes and lane-replicated data; rdata -> rdata_ext is the
// extracted and sign/zero-extended load result.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] rshift;

    always_comb begin
        wstrb = !we               ? 4'b0000 :
                func3[1:0] == 2'b00 ? 4'b0001 << addr_lo :
                func3[1:0] == 2'b01 ? 4'b0011 << {addr_lo[1], 1'b0} :
                                      4'b1111;
        wdata_rep = func3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                    func3[1:0] == 2'b01 ? {2{wdata[15:0]}} :
                                          wdata;
    end

    // Misaligned halves fall back to the lane chosen by addr[1].
    always_comb begin
        rshift    = rdata >> {addr_lo, 3'b000};
        byte_sel  = rshift[7:0];
        half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        rdata_ext = func3 == F3_B  ? {{24{byte_sel[7]}}, byte_sel} :
                    func3 == F3_BU ? {24'd0, byte_sel} :
                    func3 == F3_H  ? {{16{half_sel[15]}}, half_sel} :
                    func3 == F3_HU ? {16'd0, half_sel} :
                                     rdata;
    end

endmodule

// File: rtl/lsu_mem_iface.sv
// lsu_mem_iface: load/store unit between the multicycle controller and data memory.
// Ports: clk, reset (sync, active-low); req_* request from controller;
// busy/done/err/load_data back to controller; mem_* valid/ready memory port.
// Build option: define MISALIGN_TRAP_EN to trap misaligned halves/words
// with err instead of truncating the low address bits.
module lsu_mem_iface
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       load_data,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_t        state;
    logic [7:0]        cnt;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb;
    logic [31:0]       wdata_rep;
    logic [31:0]       rdata_ext;
    logic              err_pre;

    lsu_align u_align (
        .we        (we_q),
        .func3     (f3_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .wstrb     (wstrb),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

`ifdef MISALIGN_TRAP_EN
    assign err_pre = !f3_legal(req_we, req_func3) ||
                     (req_func3[1:0] == 2'b01 && req_addr[0]) ||
                     (req_func3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
    assign err_pre = !f3_legal(req_we, req_func3);
`endif

    assign busy      = state != S_IDLE;
    assign done      = state == S_DONE;
    assign mem_valid = state == S_ISSUE;
    assign mem_we    = mem_valid & we_q;
    assign mem_addr  = mem_valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wstrb = mem_valid ? wstrb : 4'd0;
    assign mem_wdata = mem_valid && we_q ? wdata_rep : 32'd0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            f3_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err       <= 1'b0;
            load_data <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    f3_q    <= req_func3;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    err     <= err_pre;
                    state   <= err_pre ? S_DONE : S_ISSUE;
                end
                S_ISSUE: if (mem_ready) begin
                    if (!we_q) load_data <= rdata_ext;
                    err   <= 1'b0;
                    cnt   <= '0;
                    state <= S_DONE;
                end else if (cnt == TO_LAST) begin
                    load_data <= '0;
                    err       <= 1'b1;
                    cnt       <= '0;
                    state     <= S_DONE;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                S_DONE: begin
                    err   <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_iface.sv
// tb_lsu_mem_iface: directed self-checking bench for lsu_mem_iface.
module tb_lsu_mem_iface;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_func3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        busy, done, err;
    logic [31:0] load_data;
    logic        mem_valid, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    int          checks = 0;
    int          errors = 0;

    lsu_mem_iface #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_func3 (req_func3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .load_data (load_data),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic request(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_func3 = f3;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic load_op(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_addr, input logic [31:0] exp);
        request(1'b0, f3, addr, 32'd0);
        chk({tag, "_valid"}, {31'd0, mem_valid}, 32'd1);
        chk({tag, "_addr"}, mem_addr, exp_addr);
        chk({tag, "_strb"}, {28'd0, mem_wstrb}, 32'd0);
        mem_ready = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        mem_ready = 1'b0;
        chk({tag, "_done"}, {30'd0, done, err}, 32'd2);
        chk({tag, "_data"}, load_data, exp);
        @(negedge clk);
        chk({tag, "_idle"}, {30'd0, done, busy}, 32'd0);
    endtask

    task automatic store_op(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] exp_strb, input logic [31:0] exp_wd);
        request(1'b1, f3, addr, wd);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_we"}, {31'd0, mem_we & mem_valid}, 32'd1);
            chk({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
            chk({tag, "_strb"}, {28'd0, mem_wstrb}, {28'd0, exp_strb});
            chk({tag, "_wdata"}, mem_wdata, exp_wd);
            if (i == 1) mem_ready = 1'b1;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        chk({tag, "_done"}, {30'd0, done, err}, 32'd2);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ctl", {28'd0, busy, done, err, mem_valid}, 32'd0);
        chk("rst_ld", load_data, 32'd0);
        chk("rst_mem", {mem_addr ^ mem_wdata, 3'd0, mem_we, mem_wstrb}, 40'd0);
        reset = 1'b1;

        load_op("lb", 3'b000, 32'h103, 32'h80FF1234, 32'h100, 32'hFFFFFF80);
        load_op("lhu", 3'b101, 32'h102, 32'hBEEF0000, 32'h100, 32'h0000BEEF);
        load_op("lh", 3'b001, 32'h102, 32'hBEEF0000, 32'h100, 32'hFFFFBEEF);
        load_op("lbu", 3'b100, 32'h101, 32'h80FF1234, 32'h100, 32'h00000012);
        load_op("lw", 3'b010, 32'h104, 32'hDEADBEEF, 32'h104, 32'hDEADBEEF);

        store_op("sb", 3'b000, 32'h201, 32'h000000A5, 4'b0010, 32'hA5A5A5A5);
        store_op("sh", 3'b001, 32'h202, 32'h1234ABCD, 4'b1100, 32'hABCDABCD);
        store_op("sw", 3'b010, 32'h300, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);
        chk("st_keep", load_data, 32'hDEADBEEF);

        // Timeout: 16 ISSUE cycles, with a stray request in the middle.
        request(1'b0, 3'b010, 32'h400, 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk("to_valid", {31'd0, mem_valid & ~done}, 32'd1);
            chk("to_addr", mem_addr, 32'h400);
            req_valid = i == 5;
            req_addr  = 32'h500;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("to_done", {29'd0, done, err, mem_valid}, 32'd6);
        chk("to_data", load_data, 32'd0);
        @(negedge clk);
        chk("to_idle", {30'd0, busy, mem_valid}, 32'd0);

        // Illegal func3 goes straight to DONE without touching memory.
        load_op("ld_prime", 3'b010, 32'h10, 32'h5A5A5A5A, 32'h10, 32'h5A5A5A5A);
        request(1'b0, 3'b011, 32'h600, 32'd0);
        chk("ill_ld", {29'd0, done, err, mem_valid}, 32'd6);
        chk("ill_keep", load_data, 32'h5A5A5A5A);
        request(1'b1, 3'b100, 32'h600, 32'd0);
        chk("ill_st", {29'd0, done, err, mem_valid}, 32'd6);
        @(negedge clk);

`ifdef MISALIGN_TRAP_EN
        request(1'b0, 3'b010, 32'h101, 32'd0);
        chk("mis_lw", {29'd0, done, err, mem_valid}, 32'd6);
        chk("mis_keep", load_data, 32'h5A5A5A5A);
        @(negedge clk);
        request(1'b0, 3'b001, 32'h103, 32'd0);
        chk("mis_lh", {29'd0, done, err, mem_valid}, 32'd6);
        @(negedge clk);
`else
        load_op("mis_lw", 3'b010, 32'h101, 32'h11223344, 32'h100, 32'h11223344);
        load_op("mis_lh", 3'b001, 32'h103, 32'h8765ABCD, 32'h100, 32'hFFFF8765);
`endif

        // Reset in the middle of ISSUE: no done pulse may follow.
        request(1'b0, 3'b010, 32'h700, 32'd0);
        chk("mr_issue", {31'd0, mem_valid}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mr_ctl", {29'd0, mem_valid, busy, done}, 32'd0);
        chk("mr_ld", load_data, 32'd0);
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mr_nodone", {30'd0, done, busy}, 32'd0);
        end
        mem_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
